framemask_scan: RTL and testbench

Parametrised successor to the flat-register frame mask. The pixel-select bitmap lives in an inferred two-port RAM, which the APB side writes a word at a time and which a sequential scanner reads. Given the current pixel, the scanner returns the next selected pixel in raster order to the Stonyman readout controller. It adds the following over the previous block:

- configurable resolution and word width
- word overwrite and bulk clear
- inclusive search
- a ready/valid request handshake

---
 rtl/framemask_scan.sv | 228 ++++++++++++++++++++++
 tb/tb_framemask_scan.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/framemask_scan.sv
// Pixel-select bitmap in a two-port RAM plus a sequential next-selected-pixel scanner.
// Define FRAMEMASK_WRAP_EN to let a scan wrap from the last word back round to its start word.
module framemask_scan #(
    parameter int RESOLUTION = 112,
    parameter int WORD_W     = 32,
    parameter int COORD_W    = 7,
    localparam int WPR       = (RESOLUTION + WORD_W - 1) / WORD_W,
    localparam int WSEL_W    = (WPR > 1) ? $clog2(WPR) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mask_write,
    input  logic [COORD_W-1:0] mask_row,
    input  logic [WSEL_W-1:0]  mask_word,
    input  logic [WORD_W-1:0]  mask_data,
    input  logic               mask_clear,
    output logic               mask_busy,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_row,
    input  logic [COORD_W-1:0] req_col,
    input  logic               req_incl,
    output logic               resp_valid,
    output logic               resp_found,
    output logic [COORD_W-1:0] resp_row,
    output logic [COORD_W-1:0] resp_col
);
    localparam int DEPTH  = RESOLUTION * WPR;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {CLEAR, IDLE, READ, EVAL} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_addr_reg, clr_addr_next;
    logic [COORD_W-1:0]  cur_row_reg, cur_row_next;
    logic [WSEL_W-1:0]   cur_word_reg, cur_word_next;
    logic [COORD_W-1:0]  start_row_reg, start_row_next;
    logic [WSEL_W-1:0]   start_word_reg, start_word_next;
    logic [BIT_W-1:0]    start_bit_reg, start_bit_next;
    logic                incl_reg, incl_next;
    logic                oor_reg, oor_next;
    logic                wrapped_reg, wrapped_next;
    logic                found_reg;
    logic [COORD_W-1:0]  row_reg, col_reg;

    logic [WORD_W-1:0]   mask_ram [DEPTH];
    logic [WORD_W-1:0]   rd_data_reg;
    logic                wr_en, rd_en;
    logic [ADDR_W-1:0]   wr_addr, rd_addr;
    logic [WORD_W-1:0]   wr_data;

    logic                wr_ok, first_visit, revisit, last_word, at_end;
    logic [WORD_W-1:0]   keep, eligible;
    logic                hit_any;
    logic [BIT_W-1:0]    hit_bit;
    logic                eval_found;
    logic [COORD_W-1:0]  eval_row, eval_col;

    // Read-before-write: a same-cycle write to the word being read returns the old contents.
    always_ff @(posedge clk) begin
        if (wr_en)
            mask_ram[wr_addr] <= wr_data;
        if (rd_en)
            rd_data_reg <= mask_ram[rd_addr];
    end

    assign wr_ok = (32'(mask_row) < RESOLUTION) && (32'(mask_word) < WPR);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ADDR_W'(32'(mask_row) * 32'(WPR) + 32'(mask_word));
        wr_data = mask_data;
        if (state_reg == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_reg;
            wr_data = '0;
        end else if (mask_write && wr_ok) begin
            wr_en = 1'b1;
        end
    end

    assign rd_en   = (state_reg == READ) && !oor_reg;
    assign rd_addr = ADDR_W'(32'(cur_row_reg) * 32'(WPR) + 32'(cur_word_reg));

    assign first_visit = !wrapped_reg && (cur_row_reg == start_row_reg) && (cur_word_reg == start_word_reg);
    assign revisit     = wrapped_reg && (cur_row_reg == start_row_reg) && (cur_word_reg == start_word_reg);
    assign last_word   = (cur_word_reg == WSEL_W'(WPR - 1));
    assign at_end      = last_word && (cur_row_reg == COORD_W'(RESOLUTION - 1));

    // First visit of the start word keeps bits at/after the start column; a wrapped revisit keeps those before it.
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_keep
        localparam bit IS_PAD = ((WPR - 1) * WORD_W + gi) >= RESOLUTION;
        logic at_start;
        assign at_start  = (BIT_W'(gi) == start_bit_reg) && incl_reg;
        assign keep[gi]  = !(IS_PAD && last_word) &&
                           (first_visit ? ((BIT_W'(gi) > start_bit_reg) || at_start) :
                            revisit     ? ((BIT_W'(gi) < start_bit_reg) || at_start) : 1'b1);
    end

    assign eligible = rd_data_reg & keep;

    always_comb begin
        hit_any = 1'b0;
        hit_bit = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                hit_any = 1'b1;
                hit_bit = BIT_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= CLEAR;
            clr_addr_reg   <= '0;
            cur_row_reg    <= '0;
            cur_word_reg   <= '0;
            start_row_reg  <= '0;
            start_word_reg <= '0;
            start_bit_reg  <= '0;
            incl_reg       <= 1'b0;
            oor_reg        <= 1'b0;
            wrapped_reg    <= 1'b0;
            found_reg      <= 1'b0;
            row_reg        <= '0;
            col_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            clr_addr_reg   <= clr_addr_next;
            cur_row_reg    <= cur_row_next;
            cur_word_reg   <= cur_word_next;
            start_row_reg  <= start_row_next;
            start_word_reg <= start_word_next;
            start_bit_reg  <= start_bit_next;
            incl_reg       <= incl_next;
            oor_reg        <= oor_next;
            wrapped_reg    <= wrapped_next;
            if (resp_valid) begin
                found_reg <= eval_found;
                row_reg   <= eval_row;
                col_reg   <= eval_col;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        clr_addr_next   = clr_addr_reg;
        cur_row_next    = cur_row_reg;
        cur_word_next   = cur_word_reg;
        start_row_next  = start_row_reg;
        start_word_next = start_word_reg;
        start_bit_next  = start_bit_reg;
        incl_next       = incl_reg;
        oor_next        = oor_reg;
        wrapped_next    = wrapped_reg;
        resp_valid      = 1'b0;
        eval_found      = 1'b0;
        eval_row        = '0;
        eval_col        = '0;
        case (state_reg)
            CLEAR: begin
                if (clr_addr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next    = IDLE;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr_reg + 1'b1;
                end
            end
            IDLE: begin
                if (mask_clear) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end else if (req_valid) begin
                    state_next      = READ;
                    start_row_next  = req_row;
                    start_word_next = WSEL_W'(32'(req_col) / 32'(WORD_W));
                    start_bit_next  = BIT_W'(32'(req_col) % 32'(WORD_W));
                    cur_row_next    = req_row;
                    cur_word_next   = WSEL_W'(32'(req_col) / 32'(WORD_W));
                    incl_next       = req_incl;
                    oor_next        = (32'(req_row) >= RESOLUTION) || (32'(req_col) >= RESOLUTION);
                    wrapped_next    = 1'b0;
                end
            end
            READ: state_next = EVAL;
            EVAL: begin
                if (oor_reg || revisit) begin
                    resp_valid = 1'b1;
                    state_next = IDLE;
                end else if (hit_any) begin
                    resp_valid = 1'b1;
                    eval_found = 1'b1;
                    eval_row   = cur_row_reg;
                    eval_col   = COORD_W'(32'(cur_word_reg) * 32'(WORD_W) + 32'(hit_bit));
                    state_next = IDLE;
                end else if (at_end) begin
`ifdef FRAMEMASK_WRAP_EN
                    wrapped_next  = 1'b1;
                    cur_row_next  = '0;
                    cur_word_next = '0;
                    state_next    = READ;
`else
                    resp_valid = 1'b1;
                    state_next = IDLE;
`endif
                end else begin
                    if (last_word) begin
                        cur_word_next = '0;
                        cur_row_next  = cur_row_reg + 1'b1;
                    end else begin
                        cur_word_next = cur_word_reg + 1'b1;
                    end
                    state_next = READ;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign mask_busy  = (state_reg == CLEAR);
    assign req_ready  = (state_reg == IDLE);
    assign resp_found = resp_valid ? eval_found : found_reg;
    assign resp_row   = resp_valid ? eval_row   : row_reg;
    assign resp_col   = resp_valid ? eval_col   : col_reg;
endmodule

// File: tb/tb_framemask_scan.sv
// Scoreboard bench for framemask_scan: directed requests push expected responses, a monitor pops and checks.
module tb_framemask_scan;
    localparam int DEPTH = 448;
`ifdef FRAMEMASK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mask_write = 1'b0;
    logic [6:0]  mask_row = '0;
    logic [1:0]  mask_word = '0;
    logic [31:0] mask_data = '0;
    logic        mask_clear = 1'b0;
    logic        mask_busy;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_row = '0;
    logic [6:0]  req_col = '0;
    logic        req_incl = 1'b0;
    logic        resp_valid;
    logic        resp_found;
    logic [6:0]  resp_row;
    logic [6:0]  resp_col;

    framemask_scan dut (
        .clk(clk), .reset(reset),
        .mask_write(mask_write), .mask_row(mask_row), .mask_word(mask_word), .mask_data(mask_data),
        .mask_clear(mask_clear), .mask_busy(mask_busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row), .req_col(req_col),
        .req_incl(req_incl), .resp_valid(resp_valid), .resp_found(resp_found),
        .resp_row(resp_row), .resp_col(resp_col)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic found;
        int   row;
        int   col;
        int   due;
        int   tag;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    task automatic chk(input string what, input int tag, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s[%0d]: got %0d, want %0d", what, tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (reset && resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", cyc, 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                $display("[TB] resp %0d: found=%0b row=%0d col=%0d cycle=%0d (want %0b %0d %0d @%0d)",
                         mon_e.tag, resp_found, resp_row, resp_col, cyc,
                         mon_e.found, mon_e.row, mon_e.col, mon_e.due);
                chk("found", mon_e.tag, int'(resp_found), int'(mon_e.found));
                chk("row", mon_e.tag, int'(resp_row), mon_e.row);
                chk("col", mon_e.tag, int'(resp_col), mon_e.col);
                chk("latency", mon_e.tag, cyc, mon_e.due);
            end
        end
    end

    task automatic mwrite(input int row, input int word, input logic [31:0] data);
        @(negedge clk);
        mask_write = 1'b1;
        mask_row   = 7'(row);
        mask_word  = 2'(word);
        mask_data  = data;
        @(negedge clk);
        mask_write = 1'b0;
    endtask

    task automatic count_busy(input int tag);
        int cnt;
        int bad;
        cnt = 0;
        bad = 0;
        while (mask_busy && cnt < 2000) begin
            if (req_ready) bad++;
            cnt++;
            @(negedge clk);
        end
        $display("[TB] clear %0d: busy for %0d cycles", tag, cnt);
        chk("busy_cycles", tag, cnt, DEPTH);
        chk("ready_during_clear", tag, bad, 0);
    endtask

    task automatic do_clear(input int tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 3000) begin @(negedge clk); n++; end
        mask_clear = 1'b1;
        @(negedge clk);
        mask_clear = 1'b0;
        count_busy(tag);
    endtask

    task automatic do_req(input int tag, input int row, input int col, input logic incl,
                          input logic ef, input int er, input int ec, input int lat,
                          input bit collide, input int c_row, input int c_word, input logic [31:0] c_data);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 3000) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("ready_timeout", tag, 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_row   = 7'(row);
        req_col   = 7'(col);
        req_incl  = incl;
        e.found = ef; e.row = er; e.col = ec; e.due = cyc + lat; e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (collide) begin
            mask_write = 1'b1;
            mask_row   = 7'(c_row);
            mask_word  = 2'(c_word);
            mask_data  = c_data;
            @(negedge clk);
            mask_write = 1'b0;
        end
        n = 0;
        while (sb_q.size() != 0 && n < 1200) begin @(negedge clk); n++; end
        if (sb_q.size() != 0) begin
            chk("resp_timeout", tag, 0, 1);
            sb_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, int'(mask_busy), 1);
        chk("rst_ready", 0, int'(req_ready), 0);
        chk("rst_valid", 0, int'(resp_valid), 0);
        chk("rst_found", 0, int'(resp_found), 0);
        chk("rst_row", 0, int'(resp_row), 0);
        chk("rst_col", 0, int'(resp_col), 0);
        reset = 1'b1;
        count_busy(0);

        do_req(1, 0, 0, 1'b1, 1'b0, 0, 0, WRAP ? 898 : 896, 1'b0, 0, 0, 0);
        mwrite(5, 1, 32'h0000_0100);
        do_req(2, 5, 0, 1'b0, 1'b1, 5, 40, 4, 1'b0, 0, 0, 0);
        mwrite(0, 0, 32'h0000_0001);
        do_req(3, 0, 0, 1'b1, 1'b1, 0, 0, 2, 1'b0, 0, 0, 0);
        @(negedge clk);
        chk("hold_valid", 3, int'(resp_valid), 0);
        chk("hold_found", 3, int'(resp_found), 1);
        do_req(4, 0, 0, 1'b0, 1'b1, 5, 40, 44, 1'b0, 0, 0, 0);
        mwrite(3, 3, 32'hFFFF_0000);
        mwrite(4, 0, 32'h0000_0004);
        do_req(5, 3, 0, 1'b0, 1'b1, 4, 2, 10, 1'b0, 0, 0, 0);
        do_req(6, 3, 100, 1'b1, 1'b1, 4, 2, 4, 1'b0, 0, 0, 0);
        do_req(7, 112, 0, 1'b0, 1'b0, 0, 0, 2, 1'b0, 0, 0, 0);
        do_req(8, 0, 112, 1'b1, 1'b0, 0, 0, 2, 1'b0, 0, 0, 0);

        do_clear(1);
        mwrite(2, 0, 32'h0000_0080);
        if (WRAP) do_req(9, 50, 0, 1'b0, 1'b1, 2, 7, 514, 1'b0, 0, 0, 0);
        else      do_req(9, 50, 0, 1'b0, 1'b0, 0, 0, 496, 1'b0, 0, 0, 0);
        do_req(10, 2, 0, 1'b1, 1'b1, 2, 7, 2, 1'b1, 2, 0, 32'h0000_0001);
        do_req(11, 2, 0, 1'b1, 1'b1, 2, 0, 2, 1'b0, 0, 0, 0);
        if (WRAP) do_req(12, 2, 1, 1'b0, 1'b1, 2, 0, 898, 1'b0, 0, 0, 0);
        else      do_req(12, 2, 1, 1'b0, 1'b0, 0, 0, 880, 1'b0, 0, 0, 0);

        do_clear(2);
        do_req(13, 2, 0, 1'b1, 1'b0, 0, 0, WRAP ? 898 : 880, 1'b0, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
